// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - pipeline data memory with single-cycle stores and fixed-latency loads
module data_mem_responder #(
   parameter int ADDR_BITS    = 8,
   parameter int READ_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] mem_addr,
   input  logic [15:0] mem_wdata,
   input  logic        mem_we,
   input  logic        mem_re,
   output logic [15:0] mem_rdata,
   output logic        rd_valid,
   output logic        mem_stall,
   output logic        mem_err
);

   localparam logic [0:0] IDLE      = 1'b0;
   localparam logic [0:0] READ_WAIT = 1'b1;
   localparam int         DEPTH     = 1 << ADDR_BITS;
   localparam logic [1:0] CNT_LOAD  = 2'(READ_LATENCY - 1);

   logic [0:0]  r_state;
   logic [1:0]  r_cnt;
   logic [15:0] r_addr;
   logic [15:0] r_mem [DEPTH];

   logic w_accept;
   logic w_in_range;
   logic w_lat_in_range;
   logic w_store;
   logic w_load;

   // The rd_valid cycle is not an accept slot, so a load held through completion is not re-issued.
   assign w_accept       = (r_state == IDLE) && !rd_valid;
   assign w_in_range     = (mem_addr >> ADDR_BITS) == 16'd0;
   assign w_lat_in_range = (r_addr >> ADDR_BITS) == 16'd0;
   assign w_store        = w_accept && mem_we;
   assign w_load         = w_accept && mem_re && !mem_we;
   assign mem_stall      = w_load || (r_state == READ_WAIT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= 16'h0000;
         end
      end else if (w_store && w_in_range) begin
         r_mem[mem_addr[ADDR_BITS-1:0]] <= mem_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_cnt     <= 2'd0;
         r_addr    <= 16'h0000;
         mem_rdata <= 16'h0000;
         rd_valid  <= 1'b0;
         mem_err   <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         mem_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               // A store wins over a simultaneous load; the dropped load is flagged.
               if (w_store) begin
                  mem_err <= mem_re || !w_in_range;
               end else if (w_load) begin
                  r_state <= READ_WAIT;
                  r_cnt   <= CNT_LOAD;
                  r_addr  <= mem_addr;
               end
            end
            default: begin
               if (r_cnt == 2'd0) begin
                  mem_rdata <= w_lat_in_range ? r_mem[r_addr[ADDR_BITS-1:0]] : 16'h0000;
                  rd_valid  <= 1'b1;
                  mem_err   <= !w_lat_in_range;
                  r_state   <= IDLE;
               end else begin
                  r_cnt <= r_cnt - 2'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder at read latencies 2, 1 and 4
module tb_data_mem_responder;

   typedef struct {
      logic [15:0] d;
      logic        e;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] addr  [3];
   logic [15:0] wdata [3];
   logic        we    [3];
   logic        re    [3];
   logic [15:0] rdata [3];
   logic        rv    [3];
   logic        stall [3];
   logic        err   [3];

   int   lat [3] = '{2, 1, 4};
   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   data_mem_responder #(.ADDR_BITS(8), .READ_LATENCY(2)) u_lat2 (
      .clk(clk), .rst(rst), .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_we(we[0]),
      .mem_re(re[0]), .mem_rdata(rdata[0]), .rd_valid(rv[0]), .mem_stall(stall[0]), .mem_err(err[0])
   );
   data_mem_responder #(.ADDR_BITS(8), .READ_LATENCY(1)) u_lat1 (
      .clk(clk), .rst(rst), .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_we(we[1]),
      .mem_re(re[1]), .mem_rdata(rdata[1]), .rd_valid(rv[1]), .mem_stall(stall[1]), .mem_err(err[1])
   );
   data_mem_responder #(.ADDR_BITS(8), .READ_LATENCY(4)) u_lat4 (
      .clk(clk), .rst(rst), .mem_addr(addr[2]), .mem_wdata(wdata[2]), .mem_we(we[2]),
      .mem_re(re[2]), .mem_rdata(rdata[2]), .rd_valid(rv[2]), .mem_stall(stall[2]), .mem_err(err[2])
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push(input int k, input logic [15:0] d, input logic e);
      exp_t x;
      x.d = d;
      x.e = e;
      case (k)
         0:       q0.push_back(x);
         1:       q1.push_back(x);
         default: q2.push_back(x);
      endcase
   endtask

   // Any rd_valid pulse must match the oldest expected load result of its lane.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst && rv[k] === 1'b1) begin
            exp_t x;
            int   n;
            n = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
            if (n == 0) begin
               chk($sformatf("unexpected_rd_valid_lane%0d", k), 16'd1, 16'd0);
            end else begin
               case (k)
                  0:       x = q0.pop_front();
                  1:       x = q1.pop_front();
                  default: x = q2.pop_front();
               endcase
               chk($sformatf("rdata_lane%0d", k), rdata[k], x.d);
               chk($sformatf("rd_err_lane%0d", k), {15'd0, err[k]}, {15'd0, x.e});
            end
         end
      end
   end

   // Starts just after a negedge and returns at a negedge with the lane's inputs idle.
   task automatic do_store(input int k, input logic [15:0] a, input logic [15:0] d,
                           input logic both, input logic e);
      addr[k] = a; wdata[k] = d; we[k] = 1'b1; re[k] = both;
      #1 chk("store_stall_pre", {15'd0, stall[k]}, 16'd0);
      @(posedge clk); #1;
      chk("store_err", {15'd0, err[k]}, {15'd0, e});
      chk("store_no_rv", {15'd0, rv[k]}, 16'd0);
      @(negedge clk);
      we[k] = 1'b0; re[k] = 1'b0;
      @(posedge clk); #1;
      chk("store_err_pulse_end", {15'd0, err[k]}, 16'd0);
      chk("store_no_rv_after", {15'd0, rv[k]}, 16'd0);
      @(negedge clk);
   endtask

   task automatic do_load(input int k, input logic [15:0] a, input logic [15:0] d, input logic e);
      push(k, d, e);
      addr[k] = a; we[k] = 1'b0; re[k] = 1'b1;
      #1 chk("load_stall_req", {15'd0, stall[k]}, 16'd1);
      for (int i = 0; i < lat[k]; i++) begin
         @(posedge clk); #1;
         chk($sformatf("load_stall_wait%0d", i), {15'd0, stall[k]}, 16'd1);
         chk($sformatf("load_no_rv_wait%0d", i), {15'd0, rv[k]}, 16'd0);
      end
      @(posedge clk); #1;
      chk("load_rv", {15'd0, rv[k]}, 16'd1);
      chk("load_stall_in_rv", {15'd0, stall[k]}, 16'd0);
      @(posedge clk); #1;
      chk("load_rv_one_cycle", {15'd0, rv[k]}, 16'd0);
      @(negedge clk);
      re[k] = 1'b0;
      #1 chk("load_not_reaccepted", {15'd0, stall[k]}, 16'd0);
      @(posedge clk); #1;
      chk("load_rv_quiet", {15'd0, rv[k]}, 16'd0);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 3; k++) begin
         addr[k] = 16'h0; wdata[k] = 16'h0; we[k] = 1'b0; re[k] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("reset_rdata", rdata[k], 16'h0000);
         chk("reset_rv", {15'd0, rv[k]}, 16'd0);
         chk("reset_err", {15'd0, err[k]}, 16'd0);
         chk("reset_stall", {15'd0, stall[k]}, 16'd0);
      end
      @(negedge clk);
      rst = 1'b1;

      do_store(0, 16'h0005, 16'hBEEF, 1'b0, 1'b0);
      do_load(0, 16'h0005, 16'hBEEF, 1'b0);
      do_store(0, 16'h0003, 16'h1234, 1'b1, 1'b1);
      do_load(0, 16'h0003, 16'h1234, 1'b0);
      do_store(0, 16'h0100, 16'hDEAD, 1'b0, 1'b1);
      do_load(0, 16'h0100, 16'h0000, 1'b1);
      do_load(0, 16'h0000, 16'h0000, 1'b0);
      do_store(0, 16'h0007, 16'hCAFE, 1'b0, 1'b0);
      do_load(0, 16'h0007, 16'hCAFE, 1'b0);

      do_store(1, 16'h0009, 16'h5A5A, 1'b0, 1'b0);
      do_load(1, 16'h0009, 16'h5A5A, 1'b0);
      do_store(2, 16'h00FF, 16'hA5A5, 1'b0, 1'b0);
      do_load(2, 16'h00FF, 16'hA5A5, 1'b0);
      do_load(2, 16'h8000, 16'h0000, 1'b1);

      // Reset one cycle into a load: nothing may complete afterwards.
      addr[0] = 16'h0005; re[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; re[0] = 1'b0;
      #1;
      chk("abort_rdata", rdata[0], 16'h0000);
      chk("abort_rv", {15'd0, rv[0]}, 16'd0);
      chk("abort_err", {15'd0, err[0]}, 16'd0);
      chk("abort_stall", {15'd0, stall[0]}, 16'd0);
      chk("abort_rdata_lane1", rdata[1], 16'h0000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      do_load(0, 16'h0005, 16'h0000, 1'b0);
      do_load(1, 16'h0009, 16'h0000, 1'b0);
      do_load(2, 16'h00FF, 16'h0000, 1'b0);
      repeat (4) @(negedge clk);

      chk("queue_empty_lane0", 16'(q0.size()), 16'd0);
      chk("queue_empty_lane1", 16'(q1.size()), 16'd0);
      chk("queue_empty_lane2", 16'(q2.size()), 16'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
